// File: rtl/des_uart_sequencer.sv
// Byte-to-block sequencer between uart_rx/uart_tx and the DES core: gathers eight
// received bytes into a plaintext block, waits out the core latency, then streams the ciphertext back.
module des_uart_sequencer #(
    parameter int unsigned DES_LATENCY = 17,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_active,
    output logic [63:0] des_plaintext,
    input  logic [63:0] des_ciphertext,
    output logic        busy,
    output logic [7:0]  block_count,
    output logic        overrun,
    output logic        abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ENCRYPT,
        S_SEND,
        S_WAIT_ACT,
        S_WAIT_DONE
    } state_t;

    // Counters compare against "last value" so the transition fires on the edge
    // where the count would reach TIMEOUT / DES_LATENCY.
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT - 1);
    localparam logic [7:0]  LATENCY_LAST = 8'(DES_LATENCY - 1);

    state_t      state, state_d;
    logic        rx_prev;
    logic        byte_event;
    logic [63:0] asm_q, asm_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [19:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [63:0] shift_q, shift_d;
    logic [3:0]  send_cnt_q, send_cnt_d;
    logic [63:0] plain_d;
    logic [7:0]  tx_byte_d, block_count_d;
    logic        tx_start_d, abort_d, overrun_d, busy_d;

    assign byte_event = rx_valid & ~rx_prev;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state;
        asm_d         = asm_q;
        byte_cnt_d    = byte_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        shift_d       = shift_q;
        send_cnt_d    = send_cnt_q;
        plain_d       = des_plaintext;
        block_count_d = block_count;
        overrun_d     = overrun;
        abort_d       = 1'b0;
        tx_byte_d     = tx_byte;
        tx_start_d    = 1'b0;

        case (state)
            S_IDLE: begin
                if (byte_event) begin
                    asm_d      = {asm_q[55:0], rx_byte};
                    byte_cnt_d = 4'd1;
                    idle_cnt_d = '0;
                    state_d    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A byte arriving on the timeout cycle takes priority over the abort.
                if (byte_event) begin
                    asm_d      = {asm_q[55:0], rx_byte};
                    idle_cnt_d = '0;
                    if (byte_cnt_q == 4'd7) begin
                        plain_d    = {asm_q[55:0], rx_byte};
                        byte_cnt_d = '0;
                        wait_cnt_d = '0;
                        state_d    = S_ENCRYPT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end else if (idle_cnt_q == TIMEOUT_LAST) begin
                    abort_d    = 1'b1;
                    asm_d      = '0;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 20'd1;
                end
            end
            S_ENCRYPT: begin
                if (wait_cnt_q == LATENCY_LAST) begin
                    shift_d    = des_ciphertext;
                    send_cnt_d = 4'd8;
                    wait_cnt_d = '0;
                    state_d    = S_SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                if (tx_active) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_active) begin
                    shift_d    = {shift_q[55:0], 8'h00};
                    send_cnt_d = send_cnt_q - 4'd1;
                    if (send_cnt_q == 4'd1) begin
                        block_count_d = block_count + 8'd1;
                        state_d       = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (byte_event && !(state inside {S_IDLE, S_COLLECT})) overrun_d = 1'b1;

        // Outputs are registered from the next state so they line up with the state itself.
        if (state_d == S_SEND) begin
            tx_start_d = 1'b1;
            tx_byte_d  = shift_d[63:56];
        end
        busy_d = !(state_d inside {S_IDLE, S_COLLECT});
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rx_prev       <= 1'b0;
            asm_q         <= '0;
            byte_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            shift_q       <= '0;
            send_cnt_q    <= '0;
            des_plaintext <= '0;
            block_count   <= '0;
            overrun       <= 1'b0;
            abort         <= 1'b0;
            tx_byte       <= '0;
            tx_start      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            rx_prev       <= rx_valid;
            asm_q         <= asm_d;
            byte_cnt_q    <= byte_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            shift_q       <= shift_d;
            send_cnt_q    <= send_cnt_d;
            des_plaintext <= plain_d;
            block_count   <= block_count_d;
            overrun       <= overrun_d;
            abort         <= abort_d;
            tx_byte       <= tx_byte_d;
            tx_start      <= tx_start_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_des_uart_sequencer.sv
// Bench for des_uart_sequencer: two instances (long latency / default timeout, and
// latency 1 / timeout 50) driven by directed and random blocks, with UART-TX and DES models.
module tb_des_uart_sequencer;

    localparam int CLK_PERIOD = 10;
    localparam int LAT_A      = 17;
    localparam int LAT_B      = 1;
    localparam int TO_B       = 50;
    localparam int DONE_LIMIT = 3000;

    logic clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    logic        rst_n;
    logic        rx_valid [2];
    logic [7:0]  rx_byte  [2];

    logic [7:0]  a_tx_byte, b_tx_byte;
    logic        a_tx_start, b_tx_start;
    logic        a_tx_active, b_tx_active;
    logic [63:0] a_plain, b_plain;
    logic [63:0] a_ct = '0, b_ct = '0;
    logic [63:0] a_snap, b_snap;
    logic        a_busy, b_busy;
    logic [7:0]  a_bc, b_bc;
    logic        a_ovr, b_ovr, a_abort, b_abort;

    des_uart_sequencer #(.DES_LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid[0]), .rx_byte(rx_byte[0]),
        .tx_byte(a_tx_byte), .tx_start(a_tx_start), .tx_active(a_tx_active),
        .des_plaintext(a_plain), .des_ciphertext(a_ct), .busy(a_busy),
        .block_count(a_bc), .overrun(a_ovr), .abort(a_abort)
    );

    des_uart_sequencer #(.DES_LATENCY(LAT_B), .TIMEOUT(TO_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid[1]), .rx_byte(rx_byte[1]),
        .tx_byte(b_tx_byte), .tx_start(b_tx_start), .tx_active(b_tx_active),
        .des_plaintext(b_plain), .des_ciphertext(b_ct), .busy(b_busy),
        .block_count(b_bc), .overrun(b_ovr), .abort(b_abort)
    );

    // DES model: result is garbage until the latency has elapsed after a plaintext change.
    always @(a_plain) begin
        a_ct   = 64'hDEAD_BEEF_0BAD_F00D;
        a_snap = a_plain;
        #(LAT_A * CLK_PERIOD - 1);
        a_ct   = a_snap ^ {64{1'b1}};
    end
    always @(b_plain) begin
        b_ct   = 64'hDEAD_BEEF_0BAD_F00D;
        b_snap = b_plain;
        #(LAT_B * CLK_PERIOD - 1);
        b_ct   = b_snap ^ {64{1'b1}};
    end

    // UART transmitter models: record each requested byte, then run a short frame.
    logic [7:0] tx_log_a [$];
    logic [7:0] tx_log_b [$];
    int a_starts = 0, b_starts = 0, a_aborts = 0, b_aborts = 0;

    initial begin
        a_tx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (a_tx_start === 1'b1) begin
                tx_log_a.push_back(a_tx_byte);
                repeat (2) @(negedge clk);
                a_tx_active = 1'b1;
                repeat (4) @(negedge clk);
                a_tx_active = 1'b0;
            end
        end
    end
    initial begin
        b_tx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (b_tx_start === 1'b1) begin
                tx_log_b.push_back(b_tx_byte);
                repeat (2) @(negedge clk);
                b_tx_active = 1'b1;
                repeat (4) @(negedge clk);
                b_tx_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (a_tx_start === 1'b1) a_starts++;
        if (b_tx_start === 1'b1) b_starts++;
        if (a_abort === 1'b1)    a_aborts++;
        if (b_abort === 1'b1)    b_aborts++;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count [2];
    int base_starts [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input int d);
        return (d == 0) ? a_busy : b_busy;
    endfunction
    function automatic int starts_of(input int d);
        return (d == 0) ? a_starts : b_starts;
    endfunction

    task automatic reset_checks(input int d, input string tag);
        check({tag, "_tx_byte"},  64'((d == 0) ? a_tx_byte  : b_tx_byte),  64'd0);
        check({tag, "_tx_start"}, 64'((d == 0) ? a_tx_start : b_tx_start), 64'd0);
        check({tag, "_plain"},    (d == 0) ? a_plain : b_plain,            64'd0);
        check({tag, "_busy"},     64'(busy_of(d)),                         64'd0);
        check({tag, "_count"},    64'((d == 0) ? a_bc : b_bc),             64'd0);
        check({tag, "_overrun"},  64'((d == 0) ? a_ovr : b_ovr),           64'd0);
        check({tag, "_abort"},    64'((d == 0) ? a_abort : b_abort),       64'd0);
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input int gap);
        rx_byte[d]  = b;
        rx_valid[d] = 1'b1;
        @(negedge clk);
        rx_valid[d] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic begin_block(input int d);
        if (d == 0) tx_log_a.delete(); else tx_log_b.delete();
        base_starts[d] = starts_of(d);
    endtask

    // Bytes go out most-significant first; gap must be >= 1 so each byte is a fresh edge.
    task automatic send_block(input int d, input logic [63:0] blk, input int gap, input int first);
        for (int i = first; i < 8; i++)
            send_byte(d, blk[63 - 8 * i -: 8], (i == 7) ? 0 : gap);
    endtask

    task automatic finish_block(input int d, input logic [63:0] blk, input string tag);
        int          n;
        int          sz;
        logic [63:0] obs;
        logic [7:0]  v;
        check({tag, "_busy"}, 64'(busy_of(d)), 64'd1);
        n = 0;
        while (busy_of(d) !== 1'b0 && n < DONE_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_time"}, 64'(n < DONE_LIMIT), 64'd1);
        exp_count[d] = (exp_count[d] + 1) % 256;
        check({tag, "_plain"}, (d == 0) ? a_plain : b_plain, blk);
        check({tag, "_count"}, 64'((d == 0) ? a_bc : b_bc), 64'(exp_count[d]));
        check({tag, "_starts"}, 64'(starts_of(d) - base_starts[d]), 64'd8);
        sz  = (d == 0) ? tx_log_a.size() : tx_log_b.size();
        obs = '0;
        for (int i = 0; i < 8; i++) begin
            v = 8'h00;
            if (i < sz) v = (d == 0) ? tx_log_a[i] : tx_log_b[i];
            obs = {obs[55:0], v};
        end
        check({tag, "_tx_bytes"}, obs, blk ^ {64{1'b1}});
        check({tag, "_tx_len"}, 64'(sz), 64'd8);
    endtask

    task automatic run_block(input int d, input logic [63:0] blk, input int gap, input string tag);
        begin_block(d);
        send_block(d, blk, gap, 0);
        finish_block(d, blk, tag);
    endtask

    initial begin
        #(80000 * CLK_PERIOD);
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] blk;
        int          n;
        int          ab0;

        rst_n       = 1'b0;
        rx_valid[0] = 1'b0; rx_valid[1] = 1'b0;
        rx_byte[0]  = 8'h00; rx_byte[1]  = 8'h00;
        exp_count[0] = 0; exp_count[1] = 0;
        repeat (3) @(negedge clk);
        reset_checks(0, "rst_a");
        reset_checks(1, "rst_b");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_block(0, 64'h0102_0304_0506_0708, 100, "block_path");

        for (int k = 0; k < 3; k++) begin
            blk = {$urandom, $urandom};
            run_block(0, blk, $urandom_range(1, 30), "rand_block");
        end

        // A level held high for 500 cycles is a single byte.
        blk = {8'hAA, $urandom_range(0, 255) << 48 | 56'({$urandom, $urandom})};
        begin_block(0);
        rx_byte[0]  = 8'hAA;
        rx_valid[0] = 1'b1;
        repeat (500) @(negedge clk);
        rx_valid[0] = 1'b0;
        check("held_not_busy", 64'(a_busy), 64'd0);
        repeat (5) @(negedge clk);
        send_block(0, blk, 3, 1);
        finish_block(0, blk, "held");

        // Byte dropped while a frame is in flight.
        check("overrun_clear", 64'(a_ovr), 64'd0);
        blk = {$urandom, $urandom};
        begin_block(0);
        send_block(0, blk, 2, 0);
        n = 0;
        while (a_tx_active !== 1'b1 && n < DONE_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("overrun_frame_seen", 64'(n < DONE_LIMIT), 64'd1);
        @(negedge clk);
        send_byte(0, 8'h5A, 0);
        check("overrun_set", 64'(a_ovr), 64'd1);
        finish_block(0, blk, "overrun_block");
        blk = {$urandom, $urandom};
        run_block(0, blk, 4, "after_overrun");
        check("overrun_sticky", 64'(a_ovr), 64'd1);

        // Reset one cycle after the third transmit request.
        blk = {$urandom, $urandom};
        begin_block(0);
        send_block(0, blk, 2, 0);
        n = 0;
        while (a_starts - base_starts[0] < 3 && n < DONE_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_third_start", 64'(n < DONE_LIMIT), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        reset_checks(0, "rst_mid");
        rst_n = 1'b1;
        exp_count[0] = 0; exp_count[1] = 0;
        base_starts[0] = a_starts;
        repeat (300) @(negedge clk);
        check("rst_mid_no_start", 64'(a_starts - base_starts[0]), 64'd0);
        blk = {$urandom, $urandom};
        run_block(0, blk, 5, "after_reset");

        // Partial block discarded after TIMEOUT idle cycles.
        ab0 = b_aborts;
        for (int i = 0; i < 3; i++) send_byte(1, 8'($urandom), 2);
        repeat (45) @(negedge clk);
        check("timeout_not_yet", 64'(b_aborts - ab0), 64'd0);
        repeat (10) @(negedge clk);
        check("timeout_abort", 64'(b_aborts - ab0), 64'd1);
        check("timeout_count", 64'(b_bc), 64'(exp_count[1]));
        check("timeout_idle", 64'(b_busy), 64'd0);
        // Gaps of TIMEOUT-1 idle cycles put each byte on the timeout cycle itself.
        run_block(1, 64'h1112_1314_1516_1718, TO_B - 1, "after_timeout");
        check("timeout_single_abort", 64'(b_aborts - ab0), 64'd1);

        // block_count wraps modulo 256.
        for (int k = 0; k < 256; k++) begin
            blk = {$urandom, $urandom};
            run_block(1, blk, 1, "wrap");
            if (exp_count[1] == 255) check("wrap_255", 64'(b_bc), 64'd255);
            if (exp_count[1] == 0)   check("wrap_0", 64'(b_bc), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
